// File: rtl/jt6295_interp.sv
// Linear interpolator for the jt6295 sound output: ramps between samples on every cen tick.
// Define JT6295_INTERP_ROUND_EN to round the output to nearest instead of truncating.
module jt6295_interp #(
  parameter int FRAC = 10,
  parameter int PERW = 9
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cen,
  input  logic                   cen_sr,
  input  logic signed [13:0]     sound_in,
  output logic signed [13:0]     sound_out,
  output logic        [PERW-1:0] period,
  output logic                   busy
);

  localparam int AW = 15 + FRAC;
  localparam int DW = 15 + FRAC;
  localparam int CW = $clog2(DW);

  typedef enum logic [1:0] {IDLE, DIV, RUN} state_t;

  state_t                state;
  logic                  valid;
  logic                  neg;
  logic       [PERW-1:0] cnt;
  logic       [PERW-1:0] den;
  logic       [PERW-1:0] rem;
  logic       [DW-1:0]   dvd;
  logic       [CW-1:0]   bitcnt;
  logic signed [AW-1:0]  acc;
  logic signed [AW-1:0]  step;
  logic signed [13:0]    target;

  logic                  strobe;
  logic       [PERW-1:0] new_period;
  logic signed [14:0]    new_delta;
  logic       [14:0]     mag;
  logic signed [AW-1:0]  tgt_acc;
  logic       [PERW:0]   rem_sh;
  logic                  ge;
  logic       [PERW-1:0] rem_nx;
  logic       [DW-1:0]   q;
  logic signed [AW-1:0]  step_nx;
  logic signed [AW:0]    sum;
  logic signed [AW:0]    tgt_ext;
  logic signed [AW-1:0]  run_nx;
  logic signed [13:0]    out_nx;

  assign strobe = cen & cen_sr;

  always_comb begin
    new_period = (cnt == '1) ? cnt : cnt + 1'b1;
    new_delta  = {sound_in[13], sound_in} - {target[13], target};
    mag        = new_delta[14] ? 15'(-new_delta) : 15'(new_delta);
    tgt_acc    = {target[13], target, {FRAC{1'b0}}};
  end

  // Restoring division: the dividend register also collects the quotient bits.
  always_comb begin
    rem_sh = {rem, dvd[DW-1]};
    ge     = rem_sh >= {1'b0, den};
    rem_nx = ge ? PERW'(rem_sh - {1'b0, den}) : rem_sh[PERW-1:0];
    q      = {dvd[DW-2:0], ge};
    if (q[DW-1])
      step_nx = neg ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
    else
      step_nx = neg ? -signed'(q) : signed'(q);
  end

  // The ramp never passes the target, whatever rounding the step carries.
  always_comb begin
    sum     = {acc[AW-1], acc} + {step[AW-1], step};
    tgt_ext = {tgt_acc[AW-1], tgt_acc};
    run_nx  = sum[AW-1:0];
    if (!neg && sum > tgt_ext) run_nx = tgt_acc;
    if (neg && sum < tgt_ext)  run_nx = tgt_acc;
  end

`ifdef JT6295_INTERP_ROUND_EN
  logic signed [AW:0]      rnd;
  logic signed [AW-FRAC:0] rsh;
  always_comb begin
    rnd    = {acc[AW-1], acc} + (AW+1)'(2 ** (FRAC - 1));
    rsh    = (AW-FRAC+1)'(rnd >>> FRAC);
    out_nx = (rsh > signed'((AW-FRAC+1)'(8191))) ? 14'sd8191 : rsh[13:0];
  end
`else
  always_comb begin
    out_nx = acc[FRAC+13:FRAC];
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      valid     <= 1'b0;
      neg       <= 1'b0;
      cnt       <= '0;
      den       <= '0;
      rem       <= '0;
      dvd       <= '0;
      bitcnt    <= '0;
      acc       <= '0;
      step      <= '0;
      target    <= '0;
      sound_out <= '0;
      period    <= '0;
      busy      <= 1'b0;
    end else begin
      sound_out <= out_nx;
      if (strobe) begin
        cnt    <= '0;
        period <= new_period;
      end else if (cen && cnt != '1) begin
        cnt <= cnt + 1'b1;
      end
      if (strobe) begin
        target <= sound_in;
        step   <= '0;
        if (!valid) begin
          valid <= 1'b1;
          acc   <= {sound_in[13], sound_in, {FRAC{1'b0}}};
          state <= IDLE;
          busy  <= 1'b0;
        end else begin
          acc    <= tgt_acc;
          neg    <= new_delta[14];
          dvd    <= {mag, {FRAC{1'b0}}};
          rem    <= '0;
          den    <= new_period;
          bitcnt <= '0;
          state  <= DIV;
          busy   <= 1'b1;
        end
      end else begin
        case (state)
          IDLE: step <= '0;
          DIV: begin
            rem    <= rem_nx;
            dvd    <= q;
            bitcnt <= bitcnt + 1'b1;
            if (bitcnt == CW'(DW - 1)) begin
              step  <= step_nx;
              state <= RUN;
              busy  <= 1'b0;
            end
          end
          RUN: begin
            if (acc == tgt_acc) begin
              step  <= '0;
              state <= IDLE;
            end else if (cen) begin
              acc <= run_nx;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
